// File: rtl/nios_debug_vjtag_pkg.sv
// Shared types and constants for the Nios II debug virtual-JTAG host.
package nios_debug_vjtag_pkg;

  // Virtual-JTAG sequencing states of the host.
  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_UIR  = 3'd1,
    S_CDR  = 3'd2,
    S_SDR  = 3'd3,
    S_UDR  = 3'd4,
    S_RESP = 3'd5
  } state_t;

  // Default geometry of the debug slave's scan chain.
  localparam int DEFAULT_DR_WIDTH = 38;
  localparam int DEFAULT_IR_WIDTH = 2;

  // DR field layout, shared with the debug-slave sysclk decoder.
  localparam int DR_FLAG_HI_BIT  = 37;
  localparam int DR_FLAG_LO_BIT  = 36;
  localparam int DR_PAYLOAD_MSB  = 35;
  localparam int DR_PAYLOAD_LSB  = 0;

  // True in the states that run the test clock.
  function automatic logic is_scan_state(input state_t s);
    return (s == S_UIR) || (s == S_CDR) || (s == S_SDR) || (s == S_UDR);
  endfunction

endpackage

// File: rtl/nios_debug_vjtag_tck_gen.sv
// Test-clock generator: TCK_DIV clk cycles low, then TCK_DIV high, while run is set.
module nios_debug_vjtag_tck_gen #(
  parameter int TCK_DIV = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic run,
  output logic vji_tck,
  output logic rise_next,
  output logic fall
);

  localparam int CNT_W = (TCK_DIV > 1) ? $clog2(TCK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TCK_DIV - 1);

  logic [CNT_W-1:0] cnt;
  logic             phase_end;

  assign phase_end = run && (cnt == CNT_LAST);
  // Last low-phase cycle: tck rises at the next clk edge.
  assign rise_next = phase_end && !vji_tck;
  // Last high-phase cycle: tck falls at the next clk edge, closing the period.
  assign fall      = phase_end && vji_tck;

  // Half-period counter and tck toggle; parked low whenever run drops.
  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: sequential state uses <= so every flop samples pre-edge values.
    if (!reset_n) begin
      cnt     <= '0;
      vji_tck <= 1'b0;
    end else if (!run) begin
      cnt     <= '0;
      vji_tck <= 1'b0;
    end else if (cnt == CNT_LAST) begin
      cnt     <= '0;
      vji_tck <= ~vji_tck;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/nios_debug_vjtag_host.sv
// On-chip virtual-JTAG host: one IR load plus optional DR scan per command.
module nios_debug_vjtag_host
  import nios_debug_vjtag_pkg::*;
#(
  parameter int DR_WIDTH = DEFAULT_DR_WIDTH,
  parameter int IR_WIDTH = DEFAULT_IR_WIDTH,
  parameter int TCK_DIV  = 2
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [IR_WIDTH-1:0] cmd_ir,
  input  logic [DR_WIDTH-1:0] cmd_dr,
  input  logic                cmd_ir_only,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DR_WIDTH-1:0] rsp_data,
  output logic                vji_tck,
  output logic                vji_tdi,
  input  logic                vji_tdo,
  output logic [IR_WIDTH-1:0] vji_ir_in,
  output logic                vji_uir,
  output logic                vji_cdr,
  output logic                vji_sdr,
  output logic                vji_udr,
  output logic                vji_rti
);

  localparam int BIT_W = (DR_WIDTH > 1) ? $clog2(DR_WIDTH) : 1;
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DR_WIDTH - 1);

  state_t              state;
  state_t              next_state;
  logic                accept;
  logic                run;
  logic                rise_next;
  logic                fall;
  logic                ir_only_q;
  logic [BIT_W-1:0]    bit_cnt;
  logic [DR_WIDTH-1:0] shift_q;

  assign cmd_ready = (state == S_IDLE);
  assign accept    = cmd_valid && cmd_ready;
  assign run       = is_scan_state(state);

  nios_debug_vjtag_tck_gen #(
    .TCK_DIV (TCK_DIV)
  ) u_tck_gen (
    .clk       (clk),
    .reset_n   (reset_n),
    .run       (run),
    .vji_tck   (vji_tck),
    .rise_next (rise_next),
    .fall      (fall)
  );

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= next_state;
  end

  // Next-state decode; scan states only move on a tck period boundary.
  always_comb begin
    // NOTE: default first so no path leaves next_state unassigned (no latch).
    next_state = state;
    unique case (state)
      S_IDLE: if (accept) next_state = S_UIR;
      S_UIR:  if (fall)   next_state = ir_only_q ? S_RESP : S_CDR;
      S_CDR:  if (fall)   next_state = S_SDR;
      S_SDR:  if (fall && (bit_cnt == BIT_LAST)) next_state = S_UDR;
      S_UDR:  if (fall)   next_state = S_RESP;
      S_RESP: if (rsp_ready) next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  // Registered one-hot state flags, aligned with the state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vji_rti <= 1'b1;
      vji_uir <= 1'b0;
      vji_cdr <= 1'b0;
      vji_sdr <= 1'b0;
      vji_udr <= 1'b0;
    end else begin
      vji_rti <= (next_state == S_IDLE);
      vji_uir <= (next_state == S_UIR);
      vji_cdr <= (next_state == S_CDR);
      vji_sdr <= (next_state == S_SDR);
      vji_udr <= (next_state == S_UDR);
    end
  end

  // Command capture, DR shifting, tdi drive and response register.
  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: the shift register is reset as well, so an aborted scan leaves no stale data.
    if (!reset_n) begin
      shift_q   <= '0;
      ir_only_q <= 1'b0;
      bit_cnt   <= '0;
      vji_ir_in <= '0;
      vji_tdi   <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
    end else begin
      if (accept) begin
        shift_q   <= cmd_dr;
        ir_only_q <= cmd_ir_only;
        vji_ir_in <= cmd_ir;
        bit_cnt   <= '0;
      end else if ((state == S_SDR) && rise_next) begin
        // tdo is taken just before tck rises and enters at the MSB.
        shift_q <= {vji_tdo, shift_q[DR_WIDTH-1:1]};
      end
      if ((state == S_SDR) && fall) bit_cnt <= bit_cnt + BIT_W'(1);
      // tdi only changes on a period boundary, so it is stable across each rising tck.
      if (fall) vji_tdi <= (next_state == S_SDR) ? shift_q[0] : 1'b0;
      if ((next_state == S_RESP) && (state != S_RESP))
        rsp_data <= ir_only_q ? '0 : shift_q;
      rsp_valid <= (next_state == S_RESP);
    end
  end

endmodule

// File: tb/tb_nios_debug_vjtag_host.sv
// Scoreboard bench for nios_debug_vjtag_host with a loopback path and a 38-bit slave model.
module tb_nios_debug_vjtag_host;

  localparam int DRW = 38;
  localparam int IRW = 2;

  logic           clk = 1'b0;
  logic           reset_n = 1'b0;
  logic           cmd_valid = 1'b0;
  logic           cmd_ready;
  logic [IRW-1:0] cmd_ir = '0;
  logic [DRW-1:0] cmd_dr = '0;
  logic           cmd_ir_only = 1'b0;
  logic           rsp_valid;
  logic           rsp_ready = 1'b1;
  logic [DRW-1:0] rsp_data;
  logic           vji_tck;
  logic           vji_tdi;
  logic           vji_tdo;
  logic [IRW-1:0] vji_ir_in;
  logic           vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti;

  // Slave model: captures slave_cap on CDR, shifts on SDR, updates udr_reg on UDR.
  bit             loopback = 1'b1;
  logic [DRW-1:0] slave_cap = '0;
  logic [DRW-1:0] slave_sr = '0;
  logic [DRW-1:0] udr_reg = '0;

  assign vji_tdo = loopback ? vji_tdi : slave_sr[0];

  always #5 clk = ~clk;

  nios_debug_vjtag_host dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_ir      (cmd_ir),
    .cmd_dr      (cmd_dr),
    .cmd_ir_only (cmd_ir_only),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_data    (rsp_data),
    .vji_tck     (vji_tck),
    .vji_tdi     (vji_tdi),
    .vji_tdo     (vji_tdo),
    .vji_ir_in   (vji_ir_in),
    .vji_uir     (vji_uir),
    .vji_cdr     (vji_cdr),
    .vji_sdr     (vji_sdr),
    .vji_udr     (vji_udr),
    .vji_rti     (vji_rti)
  );

  always @(posedge vji_tck) begin
    if (vji_cdr)      slave_sr <= slave_cap;
    else if (vji_sdr) slave_sr <= {vji_tdi, slave_sr[DRW-1:1]};
    else if (vji_udr) udr_reg  <= slave_sr;
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out waiting for DUT", name);
  endtask

  // Scoreboard entry: expected data, accept-to-rsp_valid latency, tck rises, SDR visited.
  typedef struct {
    logic [DRW-1:0] data;
    int             lat;
    int             rises;
    bit             sdr;
  } exp_t;

  exp_t exp_q[$];

  int cyc = 0;
  int acc_cyc = 0;
  int tck_rises = 0;
  int sdr_rises = 0;
  bit sdr_seen = 1'b0;
  bit rsp_valid_prev = 1'b0;

  always @(posedge clk) cyc++;

  always @(posedge vji_tck) begin
    tck_rises++;
    if (vji_sdr) sdr_rises++;
  end

  // Monitor: all sampling on the falling clk edge. A value seen here is what the
  // next rising edge samples, so accept and response offsets share the same +1.
  always @(negedge clk) begin
    if (cmd_valid && cmd_ready) begin
      acc_cyc   = cyc;
      tck_rises = 0;
      sdr_rises = 0;
      sdr_seen  = 1'b0;
    end
    if (vji_sdr) sdr_seen = 1'b1;
    if (rsp_valid && !rsp_valid_prev) begin
      if (exp_q.size() == 0) check("unexpected_rsp", 64'(rsp_valid), 64'd0);
      else                   check("rsp_latency", 64'(cyc - acc_cyc), 64'(exp_q[0].lat));
    end
    if (rsp_valid && rsp_ready && exp_q.size() != 0) begin
      check("rsp_data", 64'(rsp_data), 64'(exp_q[0].data));
      check("tck_rises", 64'(tck_rises), 64'(exp_q[0].rises));
      check("sdr_seen", 64'(sdr_seen), 64'(exp_q[0].sdr));
      void'(exp_q.pop_front());
    end
    rsp_valid_prev = rsp_valid;
  end

  task automatic check_reset(input string tag);
    check({tag, "_cmd_ready"}, 64'(cmd_ready), 64'd1);
    check({tag, "_rsp_valid"}, 64'(rsp_valid), 64'd0);
    check({tag, "_rsp_data"},  64'(rsp_data),  64'd0);
    check({tag, "_tck_tdi"},   64'({vji_tck, vji_tdi}), 64'd0);
    check({tag, "_ir_in"},     64'(vji_ir_in), 64'd0);
    check({tag, "_flags"},     64'({vji_rti, vji_uir, vji_cdr, vji_sdr, vji_udr}), 64'b10000);
  endtask

  // Issue one command (called just after a rising edge); pushes its expectation.
  task automatic send(input logic [IRW-1:0] ir, input logic [DRW-1:0] dr, input bit ir_only,
                      input logic [DRW-1:0] exp_data, input int lat, input int rises);
    int guard = 0;
    while (!cmd_ready && guard < 1000) begin
      @(posedge clk); #1;
      guard++;
    end
    if (!cmd_ready) timeout_fail("cmd_ready_wait");
    exp_q.push_back('{data: exp_data, lat: lat, rises: rises, sdr: !ir_only});
    cmd_ir      = ir;
    cmd_dr      = dr;
    cmd_ir_only = ir_only;
    cmd_valid   = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    cmd_dr    = ~dr;
    cmd_ir    = ~ir;
  endtask

  task automatic wait_done(input string name, input int budget);
    int guard = 0;
    while (exp_q.size() != 0 && guard < budget) begin
      @(posedge clk);
      guard++;
    end
    if (exp_q.size() != 0) begin
      timeout_fail(name);
      exp_q.delete();
    end
    #1;
  endtask

  initial begin
    #200us;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int guard;

    // Reset values, during and after reset; tck must stay parked.
    repeat (3) @(posedge clk);
    #1;
    check_reset("rst_on");
    reset_n = 1'b1;
    repeat (10) @(posedge clk);
    @(negedge clk);
    check_reset("rst_off");
    check("idle_tck_static", 64'(tck_rises), 64'd0);
    @(posedge clk); #1;

    // Full scan in loopback; cmd_dr/cmd_ir are scrambled right after accept.
    loopback  = 1'b1;
    rsp_ready = 1'b1;
    send(2'b10, 38'h2A_5555_AAAA, 1'b0, 38'h2A_5555_AAAA, 165, 41);
    @(negedge clk);
    check("ir_in_loaded", 64'(vji_ir_in), 64'd2);
    wait_done("loopback_scan", 400);
    check("ir_in_hold", 64'(vji_ir_in), 64'd2);

    // IR-only: 5-cycle latency, data 0, one tck rise, no SDR.
    send(2'b01, 38'h00_0000_1234, 1'b1, 38'h0, 5, 1);
    wait_done("ir_only", 50);
    check("ir_only_ir_in", 64'(vji_ir_in), 64'd1);

    // Slave model: capture value returned, shifted-in value lands in UDR.
    loopback  = 1'b0;
    slave_cap = 38'h3F_0000_0001;
    send(2'b11, 38'h15_DEAD_BEEF, 1'b0, 38'h3F_0000_0001, 165, 41);
    wait_done("slave_scan", 400);
    check("slave_udr", 64'(udr_reg), 64'(38'h15_DEAD_BEEF));
    slave_cap = 38'h20_8000_0000;
    send(2'b00, 38'h00_0000_0001, 1'b0, 38'h20_8000_0000, 165, 41);
    wait_done("slave_scan2", 400);
    check("slave_udr2", 64'(udr_reg), 64'd1);

    // Backpressure, plus a command offered while busy in SDR.
    loopback  = 1'b1;
    rsp_ready = 1'b0;
    send(2'b10, 38'h0F_0F0F_0F0F, 1'b0, 38'h0F_0F0F_0F0F, 165, 41);
    guard = 0;
    do begin
      @(negedge clk);
      guard++;
    end while (!vji_sdr && guard < 100);
    if (!vji_sdr) timeout_fail("reach_sdr");
    check("busy_cmd_ready", 64'(cmd_ready), 64'd0);
    @(posedge clk); #1;
    cmd_valid   = 1'b1;
    cmd_ir      = 2'b01;
    cmd_ir_only = 1'b1;
    @(posedge clk); #1;
    cmd_valid   = 1'b0;
    cmd_ir_only = 1'b0;
    @(negedge clk);
    check("busy_ir_hold", 64'(vji_ir_in), 64'd2);
    guard = 0;
    while (!rsp_valid && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    if (!rsp_valid) timeout_fail("bp_rsp_valid");
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_valid_hold", 64'(rsp_valid), 64'd1);
      check("bp_data_hold", 64'(rsp_data), 64'(38'h0F_0F0F_0F0F));
    end
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("bp_released_valid", 64'(rsp_valid), 64'd0);
    check("bp_released_ready", 64'(cmd_ready), 64'd1);
    check("bp_queue_empty", 64'(exp_q.size()), 64'd0);

    // Reset in the middle of SDR (bit 20), then a normal command.
    @(posedge clk); #1;
    send(2'b11, 38'h3A_1234_5678, 1'b0, 38'h3A_1234_5678, 165, 41);
    guard = 0;
    while (sdr_rises < 20 && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    if (sdr_rises < 20) timeout_fail("reach_bit20");
    reset_n = 1'b0;
    exp_q.delete();
    #1;
    check_reset("mid_sdr_rst");
    repeat (3) @(negedge clk);
    check("mid_sdr_rst_hold", 64'(rsp_valid), 64'd0);
    reset_n = 1'b1;
    repeat (200) @(posedge clk);
    #1;
    check("post_rst_idle", 64'({cmd_ready, vji_rti, rsp_valid}), 64'b110);
    send(2'b01, 38'h2A_5555_AAAA, 1'b0, 38'h2A_5555_AAAA, 165, 41);
    wait_done("post_rst_scan", 400);

    repeat (5) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/nios_debug_vjtag_host.md
# nios_debug_vjtag_host

On-chip host that drives the Nios II debug slave's virtual-JTAG port from the system clock domain. It accepts one debug transaction per command: an IR value plus an optional data-register (DR) scan. It sequences the virtual-JTAG states (UIR, CDR, SDR, UDR, RTI) and generates `vji_tck`, `vji_tdi` and `vji_ir_in`. It returns the DR bits captured from `vji_tdo`. It lets self-test logic, or a bench, exercise the debug slave without an external JTAG cable.

## Interface
Parameters:
- `DR_WIDTH`, 38, debug-slave DR length in bits.
- `IR_WIDTH`, 2, virtual IR width.
- `TCK_DIV`, 2, number of `clk` cycles per `vji_tck` half-period; must be ≥1.

Ports. One clock; reset is asynchronous and active-low (`clk`, `reset_n`).
- `clk`  in  1  system clock.
- `reset_n`  in  1  asynchronous active-low reset.
- `cmd_valid`  in  1  command offered.
- `cmd_ready`  out  1  host idle; a command is accepted when `cmd_valid` and `cmd_ready` are both high.
- `cmd_ir`  in  IR_WIDTH  IR value to load.
- `cmd_dr`  in  DR_WIDTH  DR value to shift in, LSB first.
- `cmd_ir_only`  in  1  load IR only; skip the DR scan.
- `rsp_valid`  out  1  response available.
- `rsp_ready`  in  1  response consumed.
- `rsp_data`  out  DR_WIDTH  captured DR bits; 0 when `cmd_ir_only` was set.
- `vji_tck`  out  1  generated test clock.
- `vji_tdi`  out  1  serial data to the slave.
- `vji_tdo`  in  1  serial data from the slave.
- `vji_ir_in`  out  IR_WIDTH  current virtual IR.
- `vji_uir`, `vji_cdr`, `vji_sdr`, `vji_udr`, `vji_rti`  out  1 each  virtual state flags.

## Operation
- States: IDLE, UIR, CDR, SDR, UDR, RESP.
  - IDLE→UIR on accept. UIR→CDR normally, or UIR→RESP when `cmd_ir_only`.
  - CDR→SDR. SDR→UDR after DR_WIDTH tck periods. UDR→RESP.
  - RESP→IDLE when `rsp_ready`.
- State flags are one-hot. `vji_rti`=1 only in IDLE. `vji_uir`/`vji_cdr`/`vji_sdr`/`vji_udr`=1 only in their matching state.
- `vji_ir_in` loads `cmd_ir` on entry to UIR and holds until the next accepted command.
- `cmd_ready`=1 only in IDLE. `cmd_valid` asserted while busy is ignored.
- `cmd_dr` is latched at accept into a DR_WIDTH shift register. `cmd_dr` may change after accept without effect.
- SDR bit i, for i = 0..DR_WIDTH-1:
  - `vji_tdi` = shift[0] throughout the low phase of tck period i.
  - `vji_tdo` is sampled on the last `clk` of that low phase, immediately before `vji_tck` rises.
  - The sampled bit enters the shift register at the MSB and the register shifts right.
  - After DR_WIDTH bits, `rsp_data[i]` holds the i-th sampled bit.
- `vji_tdi`=0 outside SDR.
- RESP holds `rsp_valid`=1 and `rsp_data` stable until `rsp_ready`. With `rsp_ready` already high, RESP lasts exactly one cycle.

## Timing
- Reset values:
  - state IDLE, `cmd_ready`=1, `rsp_valid`=0, `rsp_data`=0.
  - `vji_tck`=0, `vji_tdi`=0, `vji_ir_in`=0, `vji_rti`=1, all other flags 0.
- All outputs are registered, except `cmd_ready`, which decodes state.
- `vji_tck` is low for TCK_DIV cycles, then high for TCK_DIV cycles. It is held at 0 in IDLE and RESP.
- Every state other than IDLE and RESP lasts whole tck periods. State changes coincide with a falling edge of `vji_tck`, so flags are stable around each rising edge.
- Latency, accept at edge T:
  - UIR starts at T+1.
  - Full scan: RESP is entered at T+1+2·TCK_DIV·(DR_WIDTH+3).
  - IR-only: RESP is entered at T+1+2·TCK_DIV.
- Reset mid-operation: all state, outputs and shift data return to reset values immediately. No response is produced.

## Structure
- Package `nios_debug_vjtag_pkg`:
  - state enum.
  - default `DR_WIDTH`/`IR_WIDTH` localparams.
  - DR field offsets shared with the debug-slave sysclk decoder: bit 37/36 command flags, bits 35:0 payload.
- Sub-module `nios_debug_vjtag_tck_gen`:
  - TCK_DIV counter with `run` input.
  - Outputs: `vji_tck`, a `rise_next` strobe (last low-phase cycle) and a `fall` strobe (period boundary).
  - The FSM advances only on `fall` and samples `vji_tdo` on `rise_next`.

## Test plan
All scenarios use default parameters.
- **Reset:** release `reset_n` → all reset values hold; `cmd_ready`=1, `vji_rti`=1, `vji_tck` static at 0.
- **Full scan with loopback:** tie `vji_tdo` to `vji_tdi`; send `cmd_dr`=38'h2A_5555_AAAA, `cmd_ir`=2'b10 → `vji_ir_in`=2'b10; `rsp_valid` at accept+165 cycles; `rsp_data`=38'h2A_5555_AAAA; exactly 41 rising tck edges.
- **IR-only:** `cmd_ir_only`=1, `cmd_ir`=2'b01 → `rsp_valid` at accept+5 cycles; `rsp_data`=0; `vji_sdr` never asserted.
- **Slave model:** 38-bit model that captures 38'h3F_0000_0001 on CDR → `rsp_data`=38'h3F_0000_0001; the model's UDR register holds `cmd_dr`.
- **Backpressure and busy:** hold `rsp_ready`=0 for 10 cycles → `rsp_valid` and `rsp_data` stable; `cmd_ready`=0; a `cmd_valid` pulse during SDR is not accepted.
- **Reset mid-SDR:** assert `reset_n`=0 at bit 20 → outputs return to reset values within the reset assertion; no `rsp_valid`; the next command completes normally.
